fpga_cfg_loader: RTL and testbench

Configuration loader for the `fpga_top` fabric. It accepts a framed 16-bit word stream over a valid/ready handshake and writes bit fields into shadow copies of the seven configuration vectors: routing blocks, switch blocks, logic blocks and the four IO rings. On a commit command it transfers all shadow vectors into the active vectors that drive `fpga_top` in a single cycle. It replaces bench-side bit poking with a synthesizable bitstream path.

---
 rtl/fpga_cfg_pkg.sv | 49 ++++
 rtl/fpga_cfg_loader_crc16.sv | 16 +
 rtl/fpga_cfg_loader.sv | 213 +++++++++++++++++++++
 tb/tb_fpga_cfg_loader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the fpga_top configuration loader: region codes,
// command bits, FSM states, default vector widths and CRC-16 constants.
// Optional build macro: FPGA_CFG_CRC_EN (CRC-protected commit).
package fpga_cfg_pkg;

  // Default configuration vector widths of the fpga_top fabric
  localparam int BRB_W_DEF = 750;
  localparam int BSB_W_DEF = 1728;
  localparam int LB_W_DEF  = 80;
  localparam int IO_W_DEF  = 20;

  // Header region codes (header bits [15:13])
  localparam logic [2:0] REG_BRB    = 3'd0;
  localparam logic [2:0] REG_BSB    = 3'd1;
  localparam logic [2:0] REG_LB     = 3'd2;
  localparam logic [2:0] REG_LEFT   = 3'd3;
  localparam logic [2:0] REG_RIGHT  = 3'd4;
  localparam logic [2:0] REG_TOP    = 3'd5;
  localparam logic [2:0] REG_BOTTOM = 3'd6;
  localparam logic [2:0] REG_CMD    = 3'd7;

  // Command bits inside the offset field of a region-7 header
  localparam int CMD_COMMIT_BIT = 0;
  localparam int CMD_CLEAR_BIT  = 1;

  // CRC-16-CCITT parameters
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_HDR    = 3'd0,
    ST_LEN    = 3'd1,
    ST_DATA   = 3'd2,
    ST_CRCW   = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  // Fold one 16-bit word into a CRC, most significant bit first
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/fpga_cfg_loader_crc16.sv
// Single-word combinational CRC-16-CCITT update used by the loader when it
// is built with FPGA_CFG_CRC_EN.
module fpga_cfg_crc16
  import fpga_cfg_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [15:0] data,
  output logic [15:0] crc_out
);

  // Next CRC after folding in one stream word
  always_comb begin
    crc_out = crc16_step(crc_in, data);
  end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Framed bitstream loader for fpga_top. Words arrive on a valid/ready
// stream, fill shadow copies of the seven configuration vectors, and a
// commit command copies every shadow vector to the active outputs at once.
// Optional build macro: FPGA_CFG_CRC_EN adds a CRC word after each commit
// header; a mismatch flags an error and suppresses the commit.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int BRB_W = BRB_W_DEF,
  parameter int BSB_W = BSB_W_DEF,
  parameter int LB_W  = LB_W_DEF,
  parameter int IO_W  = IO_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [BRB_W-1:0] brbselect,
  output logic [BSB_W-1:0] bsbselect,
  output logic [LB_W-1:0]  lbselect,
  output logic [IO_W-1:0]  leftioselect,
  output logic [IO_W-1:0]  rightioselect,
  output logic [IO_W-1:0]  topioselect,
  output logic [IO_W-1:0]  bottomioselect,
  output logic             busy,
  output logic             cfg_valid,
  output logic             err
);

  // All seven vectors live in one flat shadow/active image, packed in
  // region-code order, so a single write port and a single copy serve all.
  localparam int BASE_BSB = BRB_W;
  localparam int BASE_LB  = BASE_BSB + BSB_W;
  localparam int BASE_L   = BASE_LB + LB_W;
  localparam int BASE_R   = BASE_L + IO_W;
  localparam int BASE_T   = BASE_R + IO_W;
  localparam int BASE_B   = BASE_T + IO_W;
  localparam int TOT_W    = BASE_B + IO_W;
  localparam int POS_W    = $clog2(TOT_W);

  state_t           state_reg, state_next;
  logic             run_reg;
  logic [2:0]       region_reg;
  logic [12:0]      offset_reg;
  logic [POS_W-1:0] pos_reg;
  logic [12:0]      rem_reg;
  logic             wr_ok_reg;
  logic             err_reg;
  logic             cfg_valid_reg;
  logic [TOT_W-1:0] shadow_reg;
  logic [TOT_W-1:0] active_reg;

  logic             accept;
  logic [2:0]       hdr_region;
  logic [11:0]      len_bits;
  logic [13:0]      frame_end;
  logic [13:0]      region_w;
  logic [POS_W-1:0] region_base;
  logic             len_bad;
  logic             crc_bad;

  assign accept     = s_valid && s_ready;
  assign hdr_region = s_data[15:13];
  assign len_bits   = s_data[11:0];
  assign frame_end  = {1'b0, offset_reg} + {2'b00, len_bits};
  assign len_bad    = (|s_data[15:12]) || (frame_end > region_w);

  // Base position and width of the region named by the latched header
  always_comb begin
    region_base = '0;
    region_w    = '0;
    case (region_reg)
      REG_BRB:    begin region_base = POS_W'(0);        region_w = 14'(BRB_W); end
      REG_BSB:    begin region_base = POS_W'(BASE_BSB); region_w = 14'(BSB_W); end
      REG_LB:     begin region_base = POS_W'(BASE_LB);  region_w = 14'(LB_W);  end
      REG_LEFT:   begin region_base = POS_W'(BASE_L);   region_w = 14'(IO_W);  end
      REG_RIGHT:  begin region_base = POS_W'(BASE_R);   region_w = 14'(IO_W);  end
      REG_TOP:    begin region_base = POS_W'(BASE_T);   region_w = 14'(IO_W);  end
      REG_BOTTOM: begin region_base = POS_W'(BASE_B);   region_w = 14'(IO_W);  end
      default:    begin region_base = '0;               region_w = '0;         end
    endcase
  end

`ifdef FPGA_CFG_CRC_EN
  logic [15:0] crc_reg;
  logic [15:0] crc_next;

  fpga_cfg_crc16 u_crc (
    .crc_in  (crc_reg),
    .data    (s_data),
    .crc_out (crc_next)
  );

  // Running CRC over accepted words; restarts after each CRC check word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_reg <= CRC_INIT;
    end else if (accept) begin
      if (state_reg == ST_CRCW) crc_reg <= CRC_INIT;
      else                      crc_reg <= crc_next;
    end
  end

  assign crc_bad = (s_data != crc_reg);
`else
  assign crc_bad = 1'b0;
`endif

  // Hold s_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_reg <= 1'b0;
    else        run_reg <= 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_HDR;
    else        state_reg <= state_next;
  end

  // FSM next-state logic; the FSM only moves on accepted words except COMMIT
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_HDR: begin
        if (accept) begin
          if (hdr_region != REG_CMD) begin
            state_next = ST_LEN;
          end else if (s_data[CMD_COMMIT_BIT]) begin
`ifdef FPGA_CFG_CRC_EN
            state_next = ST_CRCW;
`else
            state_next = ST_COMMIT;
`endif
          end
        end
      end
      ST_LEN:    if (accept) state_next = (len_bits == 12'd0) ? ST_HDR : ST_DATA;
      ST_DATA:   if (accept && (rem_reg <= 13'd16)) state_next = ST_HDR;
      ST_CRCW:   if (accept) state_next = ST_COMMIT;
      ST_COMMIT: state_next = ST_HDR;
      default:   state_next = ST_HDR;
    endcase
  end

  // FSM outputs: stream ready and frame-in-progress flag
  always_comb begin
    s_ready = run_reg && (state_reg != ST_COMMIT);
    busy    = (state_reg != ST_HDR);
  end

  // Frame datapath: header/length capture, shadow writes, error and commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      region_reg    <= '0;
      offset_reg    <= '0;
      pos_reg       <= '0;
      rem_reg       <= '0;
      wr_ok_reg     <= 1'b0;
      err_reg       <= 1'b0;
      cfg_valid_reg <= 1'b0;
      shadow_reg    <= '0;
      active_reg    <= '0;
    end else begin
      if (accept) begin
        case (state_reg)
          ST_HDR: begin
            region_reg <= hdr_region;
            offset_reg <= s_data[12:0];
            // Clear happens here, so a combined clear+commit sees err=0
            if (hdr_region == REG_CMD && s_data[CMD_CLEAR_BIT]) err_reg <= 1'b0;
          end
          ST_LEN: begin
            rem_reg   <= {1'b0, len_bits};
            pos_reg   <= region_base + POS_W'(offset_reg);
            wr_ok_reg <= !len_bad;
            if (len_bad) err_reg <= 1'b1;
          end
          ST_DATA: begin
            // Bad frames still drain their data words but write nothing
            if (wr_ok_reg) begin
              for (int i = 0; i < 16; i++) begin
                if (13'(i) < rem_reg) shadow_reg[pos_reg + POS_W'(i)] <= s_data[i];
              end
            end
            pos_reg <= pos_reg + POS_W'(16);
            rem_reg <= (rem_reg > 13'd16) ? (rem_reg - 13'd16) : 13'd0;
          end
          ST_CRCW: begin
            if (crc_bad) err_reg <= 1'b1;
          end
          default: ;
        endcase
      end
      if (state_reg == ST_COMMIT && !err_reg) begin
        active_reg    <= shadow_reg;
        cfg_valid_reg <= 1'b1;
      end
    end
  end

  assign brbselect      = active_reg[BRB_W-1:0];
  assign bsbselect      = active_reg[BASE_BSB +: BSB_W];
  assign lbselect       = active_reg[BASE_LB +: LB_W];
  assign leftioselect   = active_reg[BASE_L +: IO_W];
  assign rightioselect  = active_reg[BASE_R +: IO_W];
  assign topioselect    = active_reg[BASE_T +: IO_W];
  assign bottomioselect = active_reg[BASE_B +: IO_W];
  assign cfg_valid      = cfg_valid_reg;
  assign err            = err_reg;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Scoreboard bench for fpga_cfg_loader: the driver queues the expected
// busy/err after every word and the expected active image for every commit;
// a monitor pops and compares on each accepted word and each COMMIT cycle.
// Honors FPGA_CFG_CRC_EN to append CRC words after commit headers.
module tb_fpga_cfg_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  s_data;
  logic         s_valid;
  logic         s_ready;
  logic [749:0] brbselect;
  logic [1727:0] bsbselect;
  logic [79:0]  lbselect;
  logic [19:0]  leftioselect, rightioselect, topioselect, bottomioselect;
  logic         busy, cfg_valid, err;

  always #5 clk = ~clk;

  fpga_cfg_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .brbselect      (brbselect),
    .bsbselect      (bsbselect),
    .lbselect       (lbselect),
    .leftioselect   (leftioselect),
    .rightioselect  (rightioselect),
    .topioselect    (topioselect),
    .bottomioselect (bottomioselect),
    .busy           (busy),
    .cfg_valid      (cfg_valid),
    .err            (err)
  );

  typedef struct {
    logic [749:0]  brb;
    logic [1727:0] bsb;
    logic [79:0]   lb;
    logic [19:0]   l, r, t, b;
    logic          cv;
    logic          er;
  } snap_t;

  typedef struct {
    logic [15:0] w;
    logic        busy;
    logic        er;
  } wexp_t;

  snap_t       cq[$];
  wexp_t       wq[$];
  snap_t       cur, shd;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] crc_run;

  logic        mon_acc, mon_com;
  wexp_t       mon_w;
  snap_t       mon_s;

  function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      r = (r[15] != d[i]) ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  function automatic snap_t zero_snap();
    snap_t s;
    s.brb = '0; s.bsb = '0; s.lb = '0;
    s.l = '0; s.r = '0; s.t = '0; s.b = '0;
    s.cv = 1'b0; s.er = 1'b0;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [767:0] act, input logic [767:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outputs(input string p, input snap_t e);
    chk({p, "_brb"},       768'(brbselect),           768'(e.brb));
    chk({p, "_bsb_lo"},    768'(bsbselect[575:0]),    768'(e.bsb[575:0]));
    chk({p, "_bsb_mid"},   768'(bsbselect[1151:576]), 768'(e.bsb[1151:576]));
    chk({p, "_bsb_hi"},    768'(bsbselect[1727:1152]), 768'(e.bsb[1727:1152]));
    chk({p, "_lb"},        768'(lbselect),            768'(e.lb));
    chk({p, "_left"},      768'(leftioselect),        768'(e.l));
    chk({p, "_right"},     768'(rightioselect),       768'(e.r));
    chk({p, "_top"},       768'(topioselect),         768'(e.t));
    chk({p, "_bottom"},    768'(bottomioselect),      768'(e.b));
    chk({p, "_cfg_valid"}, 768'(cfg_valid),           768'(e.cv));
    chk({p, "_err"},       768'(err),                 768'(e.er));
  endtask

  // Present one word at posedge+2 and hold it until it is accepted
  task automatic drive(input logic [15:0] w);
    int n;
    n = 0;
    repeat ($urandom_range(0, 1)) begin
      @(posedge clk); #2;
    end
    s_data  = w;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake word %h: s_ready stayed 0, required 1 within 20 cycles", w);
    end
    @(posedge clk); #2;
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic send(input logic [15:0] w, input logic eb, input logic ee);
    wexp_t x;
    x.w = w; x.busy = eb; x.er = ee;
    wq.push_back(x);
    crc_run = crc_word(crc_run, w);
    drive(w);
  endtask

  task automatic send_crc(input logic [15:0] w, input logic eb, input logic ee);
    wexp_t x;
    x.w = w; x.busy = eb; x.er = ee;
    wq.push_back(x);
    drive(w);
    crc_run = 16'hFFFF;
  endtask

  // Issue a commit command; take says whether the active image must change
  task automatic commit(input logic [15:0] hdr, input bit take, input logic eh,
                        input logic ef, input bit bad_crc);
    if (take) begin
      cur    = shd;
      cur.cv = 1'b1;
    end
    cur.er = ef;
    cq.push_back(cur);
`ifdef FPGA_CFG_CRC_EN
    send(hdr, 1'b1, eh);
    send_crc(bad_crc ? (crc_run ^ 16'h0001) : crc_run, 1'b1, ef);
`else
    if (bad_crc) $display("note: CRC word requested but CRC path not built");
    send(hdr, 1'b1, eh);
`endif
    repeat (3) @(posedge clk);
    #2;
  endtask

  // Monitor: decide at negedge what the next edge does, compare just after it
  initial begin
    forever begin
      @(negedge clk);
      mon_acc = s_valid && s_ready;
      mon_com = busy && !s_ready;
      @(posedge clk); #1;
      if (mon_acc) begin
        if (wq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_accept word %h with empty scoreboard", s_data);
        end else begin
          mon_w = wq.pop_front();
          chk($sformatf("word_%h_busy", mon_w.w), 768'(busy), 768'(mon_w.busy));
          chk($sformatf("word_%h_err", mon_w.w),  768'(err),  768'(mon_w.er));
          $display("word %h accepted: busy=%0b err=%0b", mon_w.w, busy, err);
        end
      end
      if (mon_com) begin
        if (cq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_commit cfg_valid %0b with empty scoreboard", cfg_valid);
        end else begin
          mon_s = cq.pop_front();
          chk_outputs("commit", mon_s);
          $display("commit checked: cfg_valid=%0b err=%0b top=%h", cfg_valid, err, topioselect);
        end
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    crc_run = 16'hFFFF;
    shd     = zero_snap();
    cur     = zero_snap();
    repeat (3) @(posedge clk);
    #2;
    chk("reset_s_ready", 768'(s_ready), '0);
    chk("reset_busy",    768'(busy),    '0);
    chk_outputs("reset", cur);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("ready_after_release", 768'(s_ready), 768'(1));

    // Top IO, offset 0, 4 bits of 0x9; nothing visible until commit
    send(16'hA000, 1'b1, 1'b0);
    send(16'h0004, 1'b1, 1'b0);
    send(16'h0009, 1'b0, 1'b0);
    chk("top_before_commit", 768'(topioselect), '0);
    shd.t = 20'h00009;
    commit(16'hE001, 1'b1, 1'b0, 1'b0, 1'b0);

    // Routing block: last 10 bits of the region
    send(16'h02E4, 1'b1, 1'b0);
    send(16'h000A, 1'b1, 1'b0);
    send(16'h03FF, 1'b0, 1'b0);
    shd.brb[749:740] = 10'h3FF;
    commit(16'hE001, 1'b1, 1'b0, 1'b0, 1'b0);

    // Switch block: 40 bits across three data words, last word partial
    send(16'h2000, 1'b1, 1'b0);
    send(16'h0028, 1'b1, 1'b0);
    send(16'hAAAA, 1'b1, 1'b0);
    send(16'h5555, 1'b1, 1'b0);
    send(16'h00FF, 1'b0, 1'b0);
    shd.bsb[39:0] = 40'hFF_5555_AAAA;
    // Bottom IO filled exactly to its end, right IO mid-vector, zero-length left
    send(16'hC004, 1'b1, 1'b0);
    send(16'h0010, 1'b1, 1'b0);
    send(16'hBEEF, 1'b0, 1'b0);
    shd.b = 20'hBEEF0;
    send(16'h8005, 1'b1, 1'b0);
    send(16'h0003, 1'b1, 1'b0);
    send(16'h0007, 1'b0, 1'b0);
    shd.r = 20'h000E0;
    send(16'h6003, 1'b1, 1'b0);
    send(16'h0000, 1'b0, 1'b0);
    commit(16'hE001, 1'b1, 1'b0, 1'b0, 1'b0);

    // Logic block overflow: err set on the length word, data drained unwritten
    send(16'h404E, 1'b1, 1'b0);
    send(16'h0004, 1'b1, 1'b1);
    send(16'hFFFF, 1'b0, 1'b1);
    chk("err_after_overflow", 768'(err), 768'(1));
    commit(16'hE001, 1'b0, 1'b1, 1'b1, 1'b0);
    send(16'hE002, 1'b0, 1'b0);

    // Logic block exact fit on its top two bits
    send(16'h404E, 1'b1, 1'b0);
    send(16'h0002, 1'b1, 1'b0);
    send(16'h0003, 1'b0, 1'b0);
    shd.lb[79:78] = 2'b11;

    // Nonzero length high nibble: err, data dropped; clear+commit in one word
    send(16'h6000, 1'b1, 1'b0);
    send(16'h1001, 1'b1, 1'b1);
    send(16'h0001, 1'b0, 1'b1);
    commit(16'hE003, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a frame, then the next word is a header
    send(16'hA000, 1'b1, 1'b0);
    send(16'h0004, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    shd     = zero_snap();
    cur     = zero_snap();
    crc_run = 16'hFFFF;
    chk("abort_busy",    768'(busy),    '0);
    chk("abort_s_ready", 768'(s_ready), '0);
    chk_outputs("abort", cur);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    commit(16'hE001, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef FPGA_CFG_CRC_EN
    // Wrong CRC word blocks the commit; correct CRC after a clear commits
    send(16'hA000, 1'b1, 1'b0);
    send(16'h0004, 1'b1, 1'b0);
    send(16'h0003, 1'b0, 1'b0);
    shd.t = 20'h00003;
    commit(16'hE001, 1'b0, 1'b0, 1'b1, 1'b1);
    send(16'hE002, 1'b0, 1'b0);
    commit(16'hE001, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    repeat (5) @(posedge clk);
    #2;
    chk("word_queue_drained",   768'(wq.size()), '0);
    chk("commit_queue_drained", 768'(cq.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
